// File: rtl/prm_chk_pkg.sv
// Shared sizing, derived widths and result type for the programmable edge-check engine.
package prm_chk_pkg;

    localparam int unsigned KEY_W     = 15;
    localparam int unsigned NUM_CH    = 8;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned TAG_W     = 16;
    localparam int unsigned CNT_W_DEF = 32;

    // Low key bits pick the bit inside a table word; the rest address the word.
    localparam int unsigned BSEL_W  = $clog2(WORD_W);
    localparam int unsigned WADDR_W = KEY_W - BSEL_W;
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic [NUM_CH-1:0] mask;
        logic              any;
        logic [TAG_W-1:0]  tag;
    } result_t;

endpackage

// File: rtl/prm_edge_chk_engine_if.sv
// Query/result stream bundle: the master issues keys and consumes results, the slave is the engine.
interface prm_edge_chk_engine_if;
    import prm_chk_pkg::*;

    logic              q_valid;
    logic              q_ready;
    logic [KEY_W-1:0]  q_key;
    logic [TAG_W-1:0]  q_tag;
    logic              r_valid;
    logic              r_ready;
    logic [NUM_CH-1:0] r_mask;
    logic              r_any;
    logic [TAG_W-1:0]  r_tag;

    modport master (
        output q_valid, q_key, q_tag, r_ready,
        input  q_ready, r_valid, r_mask, r_any, r_tag
    );

    modport slave (
        input  q_valid, q_key, q_tag, r_ready,
        output q_ready, r_valid, r_mask, r_any, r_tag
    );

endinterface

// File: rtl/prm_chk_tbl_ram.sv
// One obstacle truth table: word-wide write port, registered read port with read enable.
module prm_chk_tbl_ram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately not reset; the read register holds while re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/prm_edge_chk_engine.sv
// Two-stage table-lookup edge checker: S1 = key/tag/enable + RAM read, S2 = result register.
module prm_edge_chk_engine
    import prm_chk_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [WADDR_W-1:0]   cfg_addr,
    input  logic [WORD_W-1:0]    cfg_wdata,
    input  logic [NUM_CH-1:0]    ch_en,
    prm_edge_chk_engine_if.slave qr,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     hit_cnt
);

    logic              rdy_q;
    logic              s1_v_q, s1_v_d;
    logic [BSEL_W-1:0] s1_bsel_q;
    logic [TAG_W-1:0]  s1_tag_q;
    logic [NUM_CH-1:0] s1_en_q;
    logic              r_valid_q, r_valid_d;
    result_t           res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept, s1_adv, deliver;
    logic [NUM_CH-1:0] tbl_we;
    logic [WORD_W-1:0] rd_word [NUM_CH];

    // rdy_q keeps q_ready low through reset and until the first clock after release.
    assign qr.q_ready = rdy_q & ~cfg_we & (~s1_v_q | ~r_valid_q | qr.r_ready);
    assign accept     = qr.q_valid & qr.q_ready;
    assign s1_adv     = s1_v_q & (~r_valid_q | qr.r_ready);
    assign deliver    = r_valid_q & qr.r_ready;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_tbl
        assign tbl_we[ch] = cfg_we && (32'(cfg_ch) == ch);

        prm_chk_tbl_ram #(
            .ADDR_W (WADDR_W),
            .DATA_W (WORD_W)
        ) u_tbl (
            .clk   (clk),
            .we    (tbl_we[ch]),
            .waddr (cfg_addr),
            .wdata (cfg_wdata),
            .re    (accept),
            .raddr (qr.q_key[KEY_W-1:BSEL_W]),
            .rdata (rd_word[ch])
        );
    end

    always_comb begin
        s1_v_d = s1_v_q;
        if (accept) begin
            s1_v_d = 1'b1;
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end
    end

    always_comb begin
        res_d     = res_q;
        r_valid_d = r_valid_q;
        if (s1_adv) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                res_d.mask[ch] = s1_en_q[ch] & rd_word[ch][s1_bsel_q];
            end
            res_d.any = |res_d.mask;
            res_d.tag = s1_tag_q;
            r_valid_d = 1'b1;
        end else if (deliver) begin
            r_valid_d = 1'b0;
        end
    end

    // Clear wins over a same-cycle increment; increments stop at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (deliver && res_q.any && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            s1_v_q    <= 1'b0;
            s1_bsel_q <= '0;
            s1_tag_q  <= '0;
            s1_en_q   <= '0;
            r_valid_q <= 1'b0;
            res_q     <= '0;
            cnt_q     <= '0;
        end else begin
            rdy_q     <= 1'b1;
            s1_v_q    <= s1_v_d;
            r_valid_q <= r_valid_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            if (accept) begin
                s1_bsel_q <= qr.q_key[BSEL_W-1:0];
                s1_tag_q  <= qr.q_tag;
                s1_en_q   <= ch_en;
            end
        end
    end

    assign qr.r_valid = r_valid_q;
    assign qr.r_mask  = res_q.mask;
    assign qr.r_any   = res_q.any;
    assign qr.r_tag   = res_q.tag;
    assign hit_cnt    = cnt_q;

endmodule

// File: tb/tb_prm_edge_chk_engine.sv
// Randomized scoreboard bench for prm_edge_chk_engine against a word/bit table model.
module tb_prm_edge_chk_engine;
    import prm_chk_pkg::*;

    localparam int unsigned TB_CNT_W = 4;
    localparam int unsigned CNT_MAX  = (1 << TB_CNT_W) - 1;
    localparam int unsigned NWORDS   = 1 << WADDR_W;
    localparam int unsigned NKEYS    = 1 << KEY_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                cfg_we = 1'b0;
    logic [CH_W-1:0]     cfg_ch = '0;
    logic [WADDR_W-1:0]  cfg_addr = '0;
    logic [WORD_W-1:0]   cfg_wdata = '0;
    logic [NUM_CH-1:0]   ch_en = '0;
    logic                cnt_clr = 1'b0;
    logic [TB_CNT_W-1:0] hit_cnt;

    prm_edge_chk_engine_if qr_if ();

    prm_edge_chk_engine #(
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .ch_en     (ch_en),
        .qr        (qr_if),
        .cnt_clr   (cnt_clr),
        .hit_cnt   (hit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] mask;
        logic              any;
        logic [TAG_W-1:0]  tag;
    } exp_t;

    exp_t              sbq[$];
    logic [WORD_W-1:0] mtbl [NUM_CH][NWORDS];
    int unsigned       exp_cnt = 0;
    int unsigned       acc_cnt = 0;
    int unsigned       stalls = 0;
    int unsigned       n_checks = 0;
    int unsigned       n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: key splits into table word (key / WORD_W) and bit (key % WORD_W).
    function automatic exp_t model(input int unsigned key, input logic [NUM_CH-1:0] en,
                                   input logic [TAG_W-1:0] tag);
        exp_t e;
        int unsigned w = key / WORD_W;
        int unsigned b = key % WORD_W;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            e.mask[ch] = en[ch] & mtbl[ch][w][b];
        end
        e.any = (e.mask != '0);
        e.tag = tag;
        return e;
    endfunction

    // Monitor: samples at the falling edge what the next rising edge will transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            exp_cnt = 0;
            check("rst_r_valid", 64'(qr_if.r_valid), 64'd0);
            check("rst_q_ready", 64'(qr_if.q_ready), 64'd0);
            check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
            check("rst_r_mask", 64'(qr_if.r_mask), 64'd0);
            check("rst_r_tag", 64'(qr_if.r_tag), 64'd0);
        end else begin
            check("hit_cnt", 64'(hit_cnt), 64'(exp_cnt));
            if (cfg_we) begin
                check("q_ready_during_cfg", 64'(qr_if.q_ready), 64'd0);
                if (int'(cfg_ch) < NUM_CH) mtbl[cfg_ch][cfg_addr] = cfg_wdata;
            end
            if (qr_if.q_valid && qr_if.q_ready) begin
                sbq.push_back(model(int'(qr_if.q_key), ch_en, qr_if.q_tag));
                acc_cnt++;
            end
            if (qr_if.r_valid && qr_if.r_ready) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: got tag 0x%0h, required no result",
                             qr_if.r_tag);
                end else begin
                    e = sbq.pop_front();
                    check("r_mask", 64'(qr_if.r_mask), 64'(e.mask));
                    check("r_any", 64'(qr_if.r_any), 64'(e.any));
                    check("r_tag", 64'(qr_if.r_tag), 64'(e.tag));
                    if (e.any && exp_cnt < CNT_MAX) exp_cnt++;
                end
            end
            if (cnt_clr) exp_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input int ch, input int unsigned addr, input logic [WORD_W-1:0] d);
        cfg_we    = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_addr  = WADDR_W'(addr);
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Presents one query and returns right after the edge that accepted it.
    task automatic send(input int unsigned key, input logic [TAG_W-1:0] tag,
                        input logic [NUM_CH-1:0] en);
        int  n = 0;
        logic acc = 1'b0;
        qr_if.q_valid = 1'b1;
        qr_if.q_key   = KEY_W'(key);
        qr_if.q_tag   = tag;
        ch_en         = en;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = qr_if.q_ready;
            n++;
            tick();
        end
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: key 0x%0h not accepted in %0d cycles", key, n);
        end
        stalls += n - 1;
        qr_if.q_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
            sbq.delete();
        end
        tick();
    endtask

    localparam int unsigned BP_KEY = 32'h1234;
    localparam int unsigned WR_KEY = 32'h0155;

    initial begin
        int unsigned acc_base;
        qr_if.q_valid = 1'b0;
        qr_if.q_key   = '0;
        qr_if.q_tag   = '0;
        qr_if.r_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("q_ready_before_first_clk", 64'(qr_if.q_ready), 64'd0);
        tick();
        @(negedge clk);
        check("q_ready_after_release", 64'(qr_if.q_ready), 64'd1);
        tick();

        // Random contents everywhere, then the directed word-0 pattern.
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int unsigned w = 0; w < NWORDS; w++) cfg_write(ch, w, $urandom());
        end
        cfg_write(0, 0, 32'h0000_0001);
        for (int ch = 1; ch < NUM_CH; ch++) cfg_write(ch, 0, 32'h0);

        // Single query: result appears in the second cycle after the accepting cycle.
        send(0, 16'h00AA, 8'hFF);
        @(negedge clk);
        check("lat_r_valid_early", 64'(qr_if.r_valid), 64'd0);
        tick();
        @(negedge clk);
        check("lat_r_valid", 64'(qr_if.r_valid), 64'd1);
        check("first_r_mask", 64'(qr_if.r_mask), 64'h01);
        check("first_r_tag", 64'(qr_if.r_tag), 64'h00AA);
        tick();
        @(negedge clk);
        check("first_hit_cnt", 64'(hit_cnt), 64'd1);
        tick();

        // Full key sweep at one query per cycle.
        stalls = 0;
        for (int unsigned k = 0; k < NKEYS; k++) send(k, TAG_W'($urandom()), 8'hFF);
        check("stream_stall_cycles", 64'(stalls), 64'd0);
        drain();

        // Back-pressure: two accepts fill the pipe; rewrite the stalled S1 key's word.
        acc_base = acc_cnt;
        qr_if.r_ready = 1'b0;
        fork
            begin
                send(32'h0777, 16'hB000, 8'hFF);
                send(BP_KEY, 16'hB001, 8'hFF);
                send(32'h2001, 16'hB002, 8'h5A);
                send(32'h7FFF, 16'hB003, 8'hFF);
            end
            begin
                int n = 0;
                while (!qr_if.r_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                repeat (5) tick();
                check("bp_accepts_while_stalled", 64'(acc_cnt - acc_base), 64'd2);
                cfg_write(3, BP_KEY / WORD_W,
                          mtbl[3][BP_KEY / WORD_W] ^ (32'h1 << (BP_KEY % WORD_W)));
                qr_if.r_ready = 1'b1;
            end
        join
        drain();

        // Write and query in the same cycle: no accept, then the new bit is seen.
        qr_if.q_valid = 1'b1;
        qr_if.q_key   = KEY_W'(WR_KEY);
        qr_if.q_tag   = 16'hC0DE;
        ch_en         = 8'hFF;
        cfg_we        = 1'b1;
        cfg_ch        = CH_W'(2);
        cfg_addr      = WADDR_W'(WR_KEY / WORD_W);
        cfg_wdata     = mtbl[2][WR_KEY / WORD_W] ^ (32'h1 << (WR_KEY % WORD_W));
        acc_base      = acc_cnt;
        @(negedge clk);
        check("cfg_blocks_q_ready", 64'(qr_if.q_ready), 64'd0);
        tick();
        cfg_we = 1'b0;
        check("cfg_cycle_accepts", 64'(acc_cnt - acc_base), 64'd0);
        send(WR_KEY, 16'hC0DE, 8'hFF);
        drain();

        // Disabled channel 0 masks the only hit for key 0.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        send(0, 16'h0E0E, 8'hFE);
        drain();
        check("masked_hit_cnt", 64'(hit_cnt), 64'd0);

        // Saturation at 15, then clear colliding with a hit.
        for (int i = 0; i < 15; i++) send(0, TAG_W'(i), 8'hFF);
        drain();
        check("cnt_at_max", 64'(hit_cnt), 64'd15);
        send(0, 16'h0F0F, 8'hFF);
        drain();
        check("cnt_saturated", 64'(hit_cnt), 64'd15);
        send(0, 16'h0C1C, 8'hFF);
        cnt_clr = 1'b1;
        tick();
        tick();
        cnt_clr = 1'b0;
        drain();
        check("cnt_clr_with_hit", 64'(hit_cnt), 64'd0);

        // Reset with two queries in flight.
        send(0, 16'h1111, 8'hFF);
        drain();
        check("pre_reset_cnt", 64'(hit_cnt), 64'd1);
        qr_if.r_ready = 1'b0;
        send(0, 16'h2222, 8'hFF);
        send(BP_KEY, 16'h3333, 8'hFF);
        rst_n = 1'b0;
        #1;
        check("async_rst_r_valid", 64'(qr_if.r_valid), 64'd0);
        check("async_rst_hit_cnt", 64'(hit_cnt), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        qr_if.r_ready = 1'b1;
        tick();
        send(0, 16'h4444, 8'hFF);
        for (int i = 0; i < 20; i++) send($urandom_range(NKEYS - 1), TAG_W'($urandom()),
                                          NUM_CH'($urandom()));
        drain();
        check("post_reset_cnt_min", 64'(hit_cnt >= 1), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prm_edge_chk_engine.md
Name: prm_edge_chk_engine

Overview:
- Programmable, pipelined successor to the fixed per-obstacle edge-check logic used by the PRM planner.
- Each of NUM_CH channels holds a 2^KEY_W x 1-bit truth table loaded at run time; the table replaces the hard-wired sum-of-products decoder.
- Accepts a stream of quantised edge keys with tags, looks each key up in all enabled channels in parallel, and returns a per-channel mask, an any-collision flag and a running collision count.
- Sits between the roadmap edge generator and the graph-pruning logic.

Parameters:
KEY_W, 15, width of the edge key (truth-table address bits)
NUM_CH, 8, number of independent obstacle-check tables
WORD_W, 32, config write word width in bits; power of two, at most 2^KEY_W
TAG_W, 16, width of the opaque edge tag carried alongside the key
CNT_W, 32, width of the saturating collision counter

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe
cfg_ch  in  clog2(NUM_CH)  channel selected for the write
cfg_addr  in  KEY_W-clog2(WORD_W)  word address within the table
cfg_wdata  in  WORD_W  table bits; bit i maps to key {cfg_addr,i}
ch_en  in  NUM_CH  per-channel enable, sampled when a query is accepted
q_valid  in  1  query valid
q_ready  out  1  query ready
q_key  in  KEY_W  edge key; bit 0 = A ... bit 14 = O
q_tag  in  TAG_W  edge tag
r_valid  out  1  result valid
r_ready  in  1  result ready
r_mask  out  NUM_CH  per-channel hit, ANDed with the sampled ch_en
r_any  out  1  OR-reduction of r_mask
r_tag  out  TAG_W  tag of the query
cnt_clr  in  1  synchronous clear of hit_cnt
hit_cnt  out  CNT_W  count of results delivered with r_any=1

Behaviour:
- Reset:
  - q_ready=0 while rst_n is low, and 1 from the first clock after release.
  - r_valid=0, r_mask=0, r_any=0, r_tag=0, hit_cnt=0, and both pipeline valids cleared.
  - Table RAM contents are not reset; they are undefined until written.
- Handshake: a transfer occurs on any edge where valid&ready. Once r_valid is asserted, it and all r_* outputs stay stable until r_ready.
- Pipeline:
  - S1 registers key, tag and ch_en, and issues a synchronous RAM read.
  - S2 is the output register.
  - Latency is exactly 2 cycles from the accept edge to r_valid.
  - Throughput is 1 result per cycle while r_ready=1.
- q_ready = !cfg_we & (!s1_v | !r_valid | r_ready). The pipeline holds at most 2 in-flight queries.
- Stall: when r_valid & !r_ready, the S1 RAM read register is held and S1 does not advance. No data loss and no duplication.
- Config write:
  - Single-cycle, one WORD_W word per cycle, into channel cfg_ch.
  - q_ready is forced to 0 in any cycle with cfg_we=1.
  - A query accepted after the write cycle observes the new data.
  - Queries already in S1/S2 keep their old result.
  - cfg_ch >= NUM_CH: the write is ignored.
- Counter:
  - hit_cnt increments on each r_valid&r_ready&r_any.
  - It saturates at 2^CNT_W-1.
  - If cnt_clr and an increment occur in the same cycle, the result is 0.
- ch_en=0 for a channel forces that mask bit to 0 for queries accepted while it is 0. Changing ch_en does not affect in-flight queries.
- Reset asserted mid-operation immediately drops all in-flight queries. No result is produced for them.

Decomposition:
- Package prm_chk_pkg holds:
  - the KEY_W/WORD_W/NUM_CH defaults;
  - derived localparams: WADDR_W = KEY_W - clog2(WORD_W) and CH_W = clog2(NUM_CH);
  - a result struct {mask, any, tag}.
- Sub-module prm_chk_tbl_ram, instantiated NUM_CH times:
  - one 2^WADDR_W x WORD_W synchronous RAM;
  - word write port;
  - read port with read-enable and word-output register;
  - bit select by key[clog2(WORD_W)-1:0] performed in the top-level S2.

Test Plan:
- Load ch0 word addr 0x0000 = 0x0000_0001 and ch1 all zero; query key 0x0000, tag 0x00AA, r_ready=1 → 2 cycles later r_valid=1, r_mask=0x01, r_any=1, r_tag=0x00AA, hit_cnt=1.
- Load every channel from the existing logicVxx sum-of-products equations; stream all 32768 keys back-to-back → one result per cycle, and r_mask[ch] matches the equation for every key.
- Stream 4 queries with r_ready low for 5 cycles after the first result → q_ready falls after 2 accepts; results are delivered in order with correct tags and none lost.
- Assert cfg_we in the same cycle as q_valid → no accept that cycle; a query of the written key on the next cycle returns the new bit.
- ch_en=0xFE with a key that hits ch0 only → r_mask=0x00, r_any=0, hit_cnt unchanged. Separately, preset hit_cnt to max (CNT_W=4, 15 hits) then one more hit → stays 15; cnt_clr with a hit → 0.
- Drop rst_n while 2 queries are in flight → r_valid=0 and hit_cnt=0 asynchronously; after release, table contents are intact and a fresh query returns the correct result.
